// File: rtl/sobel_pkg.sv
// Shared types for the Sobel edge engine: pixel/RGB types, sequencer states, gradient type.
// Also holds the RGB-to-gray weighting used on every read beat.
package sobel_pkg;

  typedef logic [7:0] pix_t;

  typedef struct packed {
    pix_t r;
    pix_t g;
    pix_t b;
  } rgb_t;

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_e;

  typedef logic signed [10:0] grad_t;

  // |Gx|+|Gy| ceiling for 8-bit inputs (4*255 per axis)
  localparam int unsigned MAG_MAX = 2040;

  function automatic pix_t rgb2gray(input rgb_t px);
    logic [9:0] sum;
    sum = {2'b00, px.r} + {1'b0, px.g, 1'b0} + {2'b00, px.b};
    return pix_t'(sum >> 2);
  endfunction

endpackage

// File: rtl/sobel_kernel.sv
// Combinational 3x3 Sobel magnitude, |Gx|+|Gy| saturated to 8 bits; zero latency, no flow control.
// With SOBEL_THRESHOLD_EN defined the result is binarised against EDGE_THRESH (0x00 / 0xFF).
module sobel_kernel
  import sobel_pkg::*;
#(
  parameter int unsigned EDGE_THRESH = 128
) (
  input  pix_t [2:0][2:0] win,
  output pix_t            m
);

  logic [10:0] x_pos, x_neg, y_pos, y_neg;
  logic [10:0] ax, ay;
  logic [11:0] mag;
  grad_t       gx, gy;

  if (EDGE_THRESH > MAG_MAX) begin : g_thresh_range
    $error("EDGE_THRESH exceeds the largest reachable gradient magnitude");
  end

  // win is indexed [row][col]
  always_comb begin
    x_pos = 11'(win[0][2]) + {2'b00, win[1][2], 1'b0} + 11'(win[2][2]);
    x_neg = 11'(win[0][0]) + {2'b00, win[1][0], 1'b0} + 11'(win[2][0]);
    y_pos = 11'(win[2][0]) + {2'b00, win[2][1], 1'b0} + 11'(win[2][2]);
    y_neg = 11'(win[0][0]) + {2'b00, win[0][1], 1'b0} + 11'(win[0][2]);
    gx    = grad_t'(x_pos - x_neg);
    gy    = grad_t'(y_pos - y_neg);
    ax    = gx[10] ? 11'(-gx) : 11'(gx);
    ay    = gy[10] ? 11'(-gy) : 11'(gy);
    mag   = 12'(ax) + 12'(ay);
`ifdef SOBEL_THRESHOLD_EN
    m     = (mag >= 12'(EDGE_THRESH)) ? 8'hFF : 8'h00;
`else
    m     = (mag > 12'd255) ? 8'hFF : mag[7:0];
`endif
  end

endmodule

// File: rtl/sobel_edge_engine.sv
// Bus-master Sobel engine: reads RGB pixels, writes (W-2)x(H-2) magnitudes; one transfer per hready strobe,
// each request held until hready, next one issued the cycle after. Output mode set by SOBEL_THRESHOLD_EN.
module sobel_edge_engine
  import sobel_pkg::*;
#(
  parameter int unsigned IMG_WIDTH   = 428,
  parameter int unsigned IMG_HEIGHT  = 428,
  parameter int unsigned IN_BASE     = 1,
  parameter int unsigned OUT_BASE    = IMG_WIDTH * IMG_HEIGHT + 1,
  parameter int unsigned EDGE_THRESH = 128
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        stop,
  output logic        done,
  output logic [31:0] haddr,
  output logic        hwrite,
  output logic [31:0] hwdata,
  input  logic [31:0] hrdata,
  input  logic        hready
);

  localparam int unsigned   CW     = $clog2(IMG_WIDTH);
  localparam int unsigned   RW     = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] C_LAST = CW'(IMG_WIDTH - 3);
  localparam logic [RW-1:0] R_LAST = RW'(IMG_HEIGHT - 3);
  localparam logic [31:0]   W32    = 32'(IMG_WIDTH);

  state_e          state, state_nxt;
  logic [CW-1:0]   col;
  logic [RW-1:0]   row;
  logic [1:0]      ld_row, ld_col, ld_row_nxt, ld_col_nxt;
  logic [31:0]     row_base, out_ptr, row_off, rd_addr_nxt;
  pix_t [2:0][2:0] win, kern_win;
  pix_t            rd_gray, m;
  logic            xfer, last_rd, last_pix;
  logic            unused_rdata_lsb;

  assign unused_rdata_lsb = ^hrdata[7:0];
  assign rd_gray  = rgb2gray(rgb_t'(hrdata[31:8]));
  assign xfer     = hready && (state == RD || state == WR);
  assign last_rd  = (ld_row == 2'd2) && (ld_col == 2'd2);
  assign last_pix = (col == C_LAST) && (row == R_LAST);

  // Load order is column-major within the window: walk rows first, then step a column.
  always_comb begin
    ld_row_nxt = ld_row + 2'd1;
    ld_col_nxt = ld_col;
    if (ld_row == 2'd2) begin
      ld_row_nxt = 2'd0;
      ld_col_nxt = ld_col + 2'd1;
    end
    case (ld_row_nxt)
      2'd1:    row_off = W32;
      2'd2:    row_off = W32 << 1;
      default: row_off = 32'd0;
    endcase
    rd_addr_nxt = row_base + row_off + 32'(col) + 32'(ld_col_nxt);
  end

  // The bottom-right pixel arrives on the same edge the write is launched, so bypass it in.
  always_comb begin
    kern_win       = win;
    kern_win[2][2] = rd_gray;
  end

  sobel_kernel #(
    .EDGE_THRESH(EDGE_THRESH)
  ) u_kernel (
    .win(kern_win),
    .m  (m)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = RD;
      RD:      if (xfer && last_rd) state_nxt = WR;
      WR:      if (xfer) state_nxt = last_pix ? DONE : RD;
      DONE:    state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
    if (stop) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      haddr    <= '0;
      hwrite   <= 1'b0;
      hwdata   <= '0;
      done     <= 1'b0;
      col      <= '0;
      row      <= '0;
      ld_row   <= '0;
      ld_col   <= '0;
      row_base <= '0;
      out_ptr  <= '0;
      win      <= '0;
    end else if (stop) begin
      hwrite <= 1'b0;
      done   <= 1'b0;
      col    <= '0;
      row    <= '0;
      ld_row <= '0;
      ld_col <= '0;
    end else begin
      case (state)
        IDLE: begin
          haddr    <= IN_BASE;
          hwrite   <= 1'b0;
          row_base <= IN_BASE;
          out_ptr  <= OUT_BASE;
        end
        RD: if (hready) begin
          win[ld_row][ld_col] <= rd_gray;
          if (last_rd) begin
            hwrite <= 1'b1;
            haddr  <= out_ptr;
            hwdata <= {8'h00, m, m, m};
          end else begin
            ld_row <= ld_row_nxt;
            ld_col <= ld_col_nxt;
            haddr  <= rd_addr_nxt;
          end
        end
        WR: if (hready) begin
          hwrite  <= 1'b0;
          out_ptr <= out_ptr + 32'd1;
          ld_row  <= 2'd0;
          if (last_pix) begin
            done <= 1'b1;
          end else if (col == C_LAST) begin
            col      <= '0;
            row      <= row + RW'(1);
            row_base <= row_base + W32;
            ld_col   <= 2'd0;
            haddr    <= row_base + W32;
          end else begin
            // Slide left; only the new right column is fetched.
            col    <= col + CW'(1);
            ld_col <= 2'd2;
            haddr  <= row_base + 32'(col) + 32'd3;
            for (int i = 0; i < 3; i++) begin
              win[i][0] <= win[i][1];
              win[i][1] <= win[i][2];
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sobel_edge_engine.sv
// Scoreboarded bench for sobel_edge_engine on a 4x4 image with a responder memory model.
module tb_sobel_edge_engine;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] dat;
  } xfer_t;

  logic        tb_clk = 1'b0;
  logic        n_rst;
  logic        stop;
  logic        done;
  logic [31:0] haddr;
  logic        hwrite;
  logic [31:0] hwdata;
  logic [31:0] hrdata;
  logic        hready;

  int checks   = 0;
  int failures = 0;

  xfer_t       exp_q[$];
  logic [31:0] mem [64];
  int          dly    = 0;
  bit          mem_en = 1'b0;

  bit          stab_en = 1'b0;
  bit          bus_ok  = 1'b1;
  logic [64:0] last_bus;
  int          viol    = 0;

  int unsigned seq_addr [28] = '{1, 5, 9, 2, 6, 10, 3, 7, 11, 17,
                                 4, 8, 12, 18,
                                 5, 9, 13, 6, 10, 14, 7, 11, 15, 19,
                                 8, 12, 16, 20};
  // Hand-derived |Gx|+|Gy| per output pixel (addresses 17..20), per image kind.
  int mag_tab [4][4] = '{'{0, 0, 0, 0},
                         '{1020, 0, 1020, 0},
                         '{28, 20, 28, 20},
                         '{120, 120, 100, 100}};
  logic [23:0] col_rgb [4] = '{24'h000000, 24'h080602, 24'h030A05, 24'h001403};
  logic [7:0]  row_v   [4] = '{8'd40, 8'd30, 8'd10, 8'd5};

  always #5 tb_clk = ~tb_clk;

  sobel_edge_engine #(
    .IMG_WIDTH  (4),
    .IMG_HEIGHT (4),
    .IN_BASE    (1),
    .OUT_BASE   (17),
    .EDGE_THRESH(128)
  ) dut (
    .clk   (tb_clk),
    .n_rst (n_rst),
    .stop  (stop),
    .done  (done),
    .haddr (haddr),
    .hwrite(hwrite),
    .hwdata(hwdata),
    .hrdata(hrdata),
    .hready(hready)
  );

  function automatic logic [7:0] exp_m(input int mag);
`ifdef SOBEL_THRESHOLD_EN
    return (mag >= 128) ? 8'hFF : 8'h00;
`else
    return (mag > 255) ? 8'hFF : 8'(mag);
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Memory responder: sees a new request, waits dly cycles, then strobes hready for one cycle.
  initial begin
    int          cnt;
    bit          served;
    logic [31:0] prev_a;
    logic        prev_w;
    cnt = 0; served = 1'b0; prev_a = '0; prev_w = 1'b0;
    hready = 1'b0;
    hrdata = '0;
    forever begin
      @(negedge tb_clk);
      hready = 1'b0;
      if (!mem_en) begin
        served = 1'b0; cnt = 0; prev_a = haddr; prev_w = hwrite;
      end else if (haddr !== prev_a || hwrite !== prev_w) begin
        served = 1'b0; cnt = 0; prev_a = haddr; prev_w = hwrite;
      end else if (!served) begin
        if (cnt >= dly) begin
          hready = 1'b1;
          served = 1'b1;
          if (hwrite) mem[haddr[5:0]] = hwdata;
          else        hrdata = mem[haddr[5:0]];
        end else begin
          cnt++;
        end
      end
    end
  end

  // Monitor: every accepted transfer is popped against the scoreboard.
  initial begin
    xfer_t       e;
    logic [64:0] cur;
    forever begin
      @(negedge tb_clk);
      #1;
      if (stab_en) begin
        cur = {haddr, hwrite, hwdata};
        if (cur !== last_bus) begin
          if (!bus_ok) viol++;
          bus_ok   = 1'b0;
          last_bus = cur;
        end
        if (hready) bus_ok = 1'b1;
      end
      if (hready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL xfer_unexpected actual addr=%0d wr=%0b data=%h required none", haddr, hwrite, hwdata);
        end else begin
          e = exp_q.pop_front();
          if (haddr !== e.addr || hwrite !== e.wr || (e.wr && hwdata !== e.dat)) begin
            failures++;
            $display("FAIL xfer actual addr=%0d wr=%0b data=%h required addr=%0d wr=%0b data=%h",
                     haddr, hwrite, hwdata, e.addr, e.wr, e.dat);
          end
        end
      end
    end
  end

  task automatic push_run(input int kind);
    xfer_t      e;
    logic [7:0] mv;
    for (int i = 0; i < 28; i++) begin
      e.addr = seq_addr[i];
      e.wr   = (seq_addr[i] >= 17);
      e.dat  = '0;
      if (e.wr) begin
        mv    = exp_m(mag_tab[kind][seq_addr[i] - 17]);
        e.dat = {8'h00, mv, mv, mv};
      end
      exp_q.push_back(e);
    end
  endtask

  task automatic load_img(input int kind);
    logic [31:0] w;
    for (int y = 0; y < 4; y++) begin
      for (int x = 0; x < 4; x++) begin
        case (kind)
          0:       w = {8'd100, 8'd100, 8'd100, 8'hA5};
          1:       w = (x == 0) ? {24'h000000, 8'h3C} : {24'hFFFFFF, 8'h3C};
          2:       w = {col_rgb[x], 8'hC3};
          default: w = {row_v[y], row_v[y], row_v[y], 8'h77};
        endcase
        mem[1 + y * 4 + x] = w;
      end
    end
  endtask

  task automatic start_run(input int kind, input int d);
    dly = d;
    exp_q.delete();
    push_run(kind);
    load_img(kind);
    @(negedge tb_clk);
    #2;
    mem_en = 1'b1;
    stop   = 1'b0;
  endtask

  task automatic finish_run(input string name);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 3000 && !found; i++) begin
      @(negedge tb_clk);
      #2;
      found = done;
    end
    check({name, "_done_rise"}, {31'd0, done}, 32'd1);
    check({name, "_queue_drained"}, exp_q.size(), 32'd0);
    mem_en = 1'b0;
    @(negedge tb_clk);
    #2;
    stop = 1'b1;
    @(negedge tb_clk);
    #2;
    check({name, "_done_cleared"}, {31'd0, done}, 32'd0);
    check({name, "_hwrite_idle"}, {31'd0, hwrite}, 32'd0);
  endtask

  initial begin
    bit got;
    n_rst = 1'b0;
    stop  = 1'b1;
    repeat (3) @(negedge tb_clk);
    #2;
    check("reset_haddr", haddr, 32'd0);
    check("reset_hwrite", {31'd0, hwrite}, 32'd0);
    check("reset_hwdata", hwdata, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    n_rst = 1'b1;
    @(negedge tb_clk);
    #2;
    check("idle_done", {31'd0, done}, 32'd0);

    start_run(0, 0); finish_run("flat");
    start_run(1, 0); finish_run("vedge");
    start_run(2, 0); finish_run("colramp");
    start_run(3, 0); finish_run("rowramp");

    start_run(1, 5);
    viol     = 0;
    bus_ok   = 1'b1;
    last_bus = {haddr, hwrite, hwdata};
    stab_en  = 1'b1;
    finish_run("slow");
    stab_en = 1'b0;
    check("slow_bus_stable_violations", viol, 32'd0);

    // Abort while the first output write is pending, then restart from scratch.
    start_run(2, 0);
    got = 1'b0;
    for (int i = 0; i < 500 && !got; i++) begin
      @(negedge tb_clk);
      #2;
      got = hwrite && !hready;
    end
    check("stop_trigger_seen", {31'd0, got}, 32'd1);
    stop   = 1'b1;
    mem_en = 1'b0;
    @(negedge tb_clk);
    #2;
    check("stop_hwrite", {31'd0, hwrite}, 32'd0);
    check("stop_done", {31'd0, done}, 32'd0);
    stop = 1'b0;
    exp_q.delete();
    push_run(2);
    @(negedge tb_clk);
    #2;
    check("restart_haddr", haddr, 32'd1);
    mem_en = 1'b1;
    finish_run("restart");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
